// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, divider state
// encodings and a small sign-fix helper.
package cpu_defines;

    // ALU operation codes carried on ex_aluop
    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_SLLV  = 8'h04;
    localparam logic [7:0] ALU_SRLV  = 8'h06;
    localparam logic [7:0] ALU_SRAV  = 8'h07;
    localparam logic [7:0] ALU_MFHI  = 8'h10;
    localparam logic [7:0] ALU_MTHI  = 8'h11;
    localparam logic [7:0] ALU_MFLO  = 8'h12;
    localparam logic [7:0] ALU_MTLO  = 8'h13;
    localparam logic [7:0] ALU_MULT  = 8'h18;
    localparam logic [7:0] ALU_MULTU = 8'h19;
    localparam logic [7:0] ALU_DIV   = 8'h1A;
    localparam logic [7:0] ALU_DIVU  = 8'h1B;
    localparam logic [7:0] ALU_ADDU  = 8'h21;
    localparam logic [7:0] ALU_SUBU  = 8'h23;
    localparam logic [7:0] ALU_AND   = 8'h24;
    localparam logic [7:0] ALU_OR    = 8'h25;
    localparam logic [7:0] ALU_XOR   = 8'h26;
    localparam logic [7:0] ALU_NOR   = 8'h27;
    localparam logic [7:0] ALU_SLT   = 8'h2A;
    localparam logic [7:0] ALU_SLTU  = 8'h2B;

    // Divider FSM encodings
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // HI/LO register pair
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider, one quotient bit per cycle.
// Signed divides run on magnitudes; signs are restored on the outputs.
module div_unit
    import cpu_defines::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [31:0]      dsr_q, dsr_d;     // divisor magnitude
    logic [31:0]      rem_q, rem_d;     // partial remainder
    logic [31:0]      a_raw_q, a_raw_d; // original dividend for the divide-by-zero result
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dz_q, dz_d;

    logic [32:0]      rem_shift;
    logic [32:0]      rem_diff;

    // Next-state, operand latch and one restoring iteration per RUN cycle
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        a_raw_d   = a_raw_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        dz_d      = dz_q;
        rem_shift = {1'b0, rem_q} << 1 | {32'd0, dvd_q[31]};
        rem_diff  = rem_shift - {1'b0, dsr_q};

        if (flush) begin
            state_d = DIV_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_d = DIV_RUN;
                        count_d = '0;
                        dvd_d   = neg_if(op_a, is_signed && op_a[31]);
                        dsr_d   = neg_if(op_b, is_signed && op_b[31]);
                        rem_d   = '0;
                        a_raw_d = op_a;
                        neg_q_d = is_signed && (op_a[31] ^ op_b[31]);
                        neg_r_d = is_signed && op_a[31];
                        dz_d    = (op_b == 32'd0);
                    end
                end
                DIV_RUN: begin
                    if (!rem_diff[32]) begin
                        rem_d = rem_diff[31:0];
                        dvd_d = {dvd_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[31:0];
                        dvd_d = {dvd_q[30:0], 1'b0};
                    end
                    if (count_q == CNT_LAST) begin
                        state_d = DIV_DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            a_raw_q <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            a_raw_q <= a_raw_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
        end
    end

    // Status and sign-corrected results; divide by zero bypasses the datapath
    always_comb begin
        busy = (state_q == DIV_RUN);
        done = (state_q == DIV_DONE);
        quot = dz_q ? '1      : neg_if(dvd_q, neg_q_q);
        rem  = dz_q ? a_raw_q : neg_if(rem_q, neg_r_q);
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU/shift/compare mux, single-cycle multiplier, HI/LO
// registers and the stall request for the multi-cycle divider.
module ex_stage
    import cpu_defines::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic [4:0]  ex_w_reg_addr,
    input  logic        ex_wd,
    input  logic        ex_inst_in_delayslot,
    input  logic        ex_flush,
    output logic [31:0] mem_wdata,
    output logic [4:0]  mem_w_reg_addr,
    output logic        mem_wd,
    output logic        mem_inst_in_delayslot,
    output logic        stall_req
);

    hilo_t       hilo_q, hilo_d;
    logic        is_div;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] result;
    logic        result_valid;

    // Divide decode and stall: hold the front of the pipe until DONE
    always_comb begin
        is_div    = (ex_aluop == ALU_DIV) || (ex_aluop == ALU_DIVU);
        div_start = is_div && !ex_flush;
        stall_req = div_start && (div_busy || !div_done);
    end

    div_unit #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .is_signed(ex_aluop == ALU_DIV),
        .op_a     (ex_rs_data),
        .op_b     (ex_rt_data),
        .flush    (ex_flush),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    // One 64-bit multiplier serves both MULT and MULTU via operand extension
    always_comb begin
        mul_signed = (ex_aluop == ALU_MULT);
        mul_a      = {{32{mul_signed && ex_rs_data[31]}}, ex_rs_data};
        mul_b      = {{32{mul_signed && ex_rt_data[31]}}, ex_rt_data};
        product    = mul_a * mul_b;
    end

    // Result mux for everything that produces a GPR value
    always_comb begin
        result       = '0;
        result_valid = 1'b1;
        case (ex_aluop)
            ALU_ADDU:  result = ex_rs_data + ex_rt_data;
            ALU_SUBU:  result = ex_rs_data - ex_rt_data;
            ALU_AND:   result = ex_rs_data & ex_rt_data;
            ALU_OR:    result = ex_rs_data | ex_rt_data;
            ALU_XOR:   result = ex_rs_data ^ ex_rt_data;
            ALU_NOR:   result = ~(ex_rs_data | ex_rt_data);
            ALU_SLT:   result = {31'd0, $signed(ex_rs_data) < $signed(ex_rt_data)};
            ALU_SLTU:  result = {31'd0, ex_rs_data < ex_rt_data};
            ALU_SLLV:  result = ex_rt_data << ex_rs_data[4:0];
            ALU_SRLV:  result = ex_rt_data >> ex_rs_data[4:0];
            ALU_SRAV:  result = $unsigned($signed(ex_rt_data) >>> ex_rs_data[4:0]);
            ALU_MFHI:  result = hilo_q.hi;
            ALU_MFLO:  result = hilo_q.lo;
            ALU_MTHI, ALU_MTLO, ALU_MULT, ALU_MULTU,
            ALU_DIV, ALU_DIVU: result = '0;
            default:   result_valid = 1'b0;
        endcase
    end

    // EX/MEM outputs
    always_comb begin
        mem_wdata             = result;
        mem_wd                = result_valid && ex_wd && !stall_req && !ex_flush;
        mem_w_reg_addr        = ex_w_reg_addr;
        mem_inst_in_delayslot = ex_inst_in_delayslot;
    end

    // HI/LO next value; annulled instructions leave HI/LO untouched
    always_comb begin
        hilo_d = hilo_q;
        if (!ex_flush) begin
            case (ex_aluop)
                ALU_MTHI:            hilo_d.hi = ex_rs_data;
                ALU_MTLO:            hilo_d.lo = ex_rs_data;
                ALU_MULT, ALU_MULTU: hilo_d    = product;
                ALU_DIV, ALU_DIVU: begin
                    if (div_done) begin
                        hilo_d.hi = div_rem;
                        hilo_d.lo = div_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    // HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hilo_q <= '0;
        end else begin
            hilo_q <= hilo_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expected results are queued when an
// instruction is driven and compared when its output is sampled.
module tb_ex_stage;
    import cpu_defines::*;

    localparam int unsigned DIV_CYCLES = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_w_reg_addr;
    logic        ex_wd;
    logic        ex_inst_in_delayslot;
    logic        ex_flush;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_w_reg_addr;
    logic        mem_wd;
    logic        mem_inst_in_delayslot;
    logic        stall_req;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        wd;
        logic [4:0]  addr;
        logic        ds;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    ex_stage #(
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_aluop             (ex_aluop),
        .ex_rs_data           (ex_rs_data),
        .ex_rt_data           (ex_rt_data),
        .ex_w_reg_addr        (ex_w_reg_addr),
        .ex_wd                (ex_wd),
        .ex_inst_in_delayslot (ex_inst_in_delayslot),
        .ex_flush             (ex_flush),
        .mem_wdata            (mem_wdata),
        .mem_w_reg_addr       (mem_w_reg_addr),
        .mem_wd               (mem_wd),
        .mem_inst_in_delayslot(mem_inst_in_delayslot),
        .stall_req            (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void div_model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drive one instruction just after the edge
    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wd, input logic fl);
        @(posedge clk);
        #1;
        ex_aluop             = op;
        ex_rs_data           = a;
        ex_rt_data           = b;
        ex_wd                = wd;
        ex_flush             = fl;
        ex_w_reg_addr        = a[4:0] ^ b[4:0] ^ 5'd9;
        ex_inst_in_delayslot = a[0];
    endtask

    // Single-cycle instruction: queue expectation, sample on the falling edge
    task automatic op(input string tag, input logic [7:0] opc, input logic [31:0] a,
                      input logic [31:0] b, input logic wd, input logic fl,
                      input logic [31:0] exp_data, input logic exp_wd);
        exp_t e;
        drive(opc, a, b, wd, fl);
        sb.push_back('{tag: tag, data: exp_data, wd: exp_wd,
                       addr: a[4:0] ^ b[4:0] ^ 5'd9, ds: a[0]});
        case (opc)
            ALU_MTHI: if (!fl) m_hi = a;
            ALU_MTLO: if (!fl) m_lo = a;
            ALU_MULT: if (!fl) {m_hi, m_lo} = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            ALU_MULTU: if (!fl) {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
            default: ;
        endcase
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".data"}, mem_wdata, e.data);
        chk({e.tag, ".wd"}, {31'd0, mem_wd}, {31'd0, e.wd});
        chk({e.tag, ".addr"}, {27'd0, mem_w_reg_addr}, {27'd0, e.addr});
        chk({e.tag, ".ds"}, {31'd0, mem_inst_in_delayslot}, {31'd0, e.ds});
    endtask

    // Full divide: count stall cycles; HI/LO land at the end of DONE
    task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        int unsigned cnt = 0;
        bit          ended = 1'b0;
        drive(s ? ALU_DIV : ALU_DIVU, a, b, 1'b1, 1'b0);
        div_model(s, a, b, m_lo, m_hi);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, ".wd_stalled"}, {31'd0, mem_wd}, 32'd0);
            if (stall_req) cnt++;
            else begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) $display("FAIL %s.timeout: stall_req never fell", tag);
        chk({tag, ".stall_cycles"}, 32'(cnt), 32'(DIV_CYCLES + 1));
    endtask

    initial begin
        rst = 1'b1;
        ex_aluop = ALU_NOP;
        ex_rs_data = '0;
        ex_rt_data = '0;
        ex_w_reg_addr = '0;
        ex_wd = 1'b0;
        ex_inst_in_delayslot = 1'b0;
        ex_flush = 1'b0;
        @(negedge clk);
        chk("rst.stall", {31'd0, stall_req}, 32'd0);
        chk("rst.wd", {31'd0, mem_wd}, 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        op("rst.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        op("rst.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);

        op("addu", ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
        op("subu", ALU_SUBU, 32'd0, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 1'b0, 32'h00F0_1200, 1'b1);
        op("or", ALU_OR, 32'hF000_0001, 32'h0000_1000, 1'b1, 1'b0, 32'hF000_1001, 1'b1);
        op("xor", ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 1'b0, 32'h5555_5555, 1'b1);
        op("nor", ALU_NOR, 32'h0000_00FF, 32'hFF00_0000, 1'b1, 1'b0, 32'h00FF_FF00, 1'b1);
        op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd1, 1'b1);
        op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1);
        op("sllv", ALU_SLLV, 32'd8, 32'h0000_00F1, 1'b1, 1'b0, 32'h0000_F100, 1'b1);
        op("srlv", ALU_SRLV, 32'd4, 32'h8000_0000, 1'b1, 1'b0, 32'h0800_0000, 1'b1);
        op("srav", ALU_SRAV, 32'd4, 32'h8000_0000, 1'b1, 1'b0, 32'hF800_0000, 1'b1);
        op("srav31", ALU_SRAV, 32'h0000_003F, 32'h8000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op("nop", ALU_NOP, 32'd3, 32'd5, 1'b1, 1'b0, 32'd0, 1'b0);
        op("undef", 8'h3F, 32'd3, 32'd5, 1'b1, 1'b0, 32'd0, 1'b0);
        op("flush_addu", ALU_ADDU, 32'd2, 32'd3, 1'b1, 1'b1, 32'd5, 1'b0);

        op("mult", ALU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
        op("mult.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFA, 1'b1);
        op("mult.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op("multu", ALU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
        op("multu.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, m_hi, 1'b1);
        op("mthi", ALU_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        op("mthi.mfhi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_1234, 1'b1);
        op("mtlo_flushed", ALU_MTLO, 32'h0000_5678, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);
        op("mtlo_flushed.mflo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, m_lo, 1'b1);

        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        op("div_m7_2.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b1);
        op("div_m7_2.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        op("divu_100_7.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, 32'd14, 1'b1);
        op("divu_100_7.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, 32'd2, 1'b1);
        do_div("div_b2b_a", 1'b1, 32'd1000, 32'hFFFF_FFF9);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        op("divu_5_0.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op("divu_5_0.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b1);

        // Flush in RUN: stall drops at once and HI/LO keep the 5/0 results
        drive(ALU_DIVU, 32'd77, 32'd3, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 ex_flush = 1'b1;
        @(negedge clk);
        chk("flush.stall", {31'd0, stall_req}, 32'd0);
        op("flush.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, m_hi, 1'b1);
        op("flush.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, m_lo, 1'b1);
        op("flush_start", ALU_DIV, 32'd9, 32'd2, 1'b0, 1'b1, 32'd0, 1'b0);
        op("flush_start.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, m_lo, 1'b1);

        // Asynchronous reset mid-divide clears HI/LO immediately
        drive(ALU_DIVU, 32'd50, 32'd4, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        ex_aluop = ALU_MFHI;
        m_hi = '0;
        m_lo = '0;
        #1;
        chk("rst_mid.hi", mem_wdata, m_hi);
        chk("rst_mid.stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        op("rst_mid.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, m_lo, 1'b1);
        do_div("post_rst_divu", 1'b0, 32'd100, 32'd7);
        op("post_rst_divu.lo", ALU_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, 32'd14, 1'b1);
        op("post_rst_divu.hi", ALU_MFHI, 32'd0, 32'd0, 1'b1, 1'b0, 32'd2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always reaches an end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS core. It sits directly downstream of the ID/EX pipeline register and consumes its `ex_*` outputs. It computes ALU, shift and compare results, owns the HI/LO registers, and runs a multi-cycle divider. Its results go combinationally to the EX/MEM register, and it raises `stall_req` to freeze the front of the pipe while a divide is in flight.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: number of divider iteration cycles (one quotient bit per cycle).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `ex_aluop`  in  8  operation code, values defined in `cpu_defines`
- `ex_rs_data`  in  32  operand A; for shifts, `[4:0]` is the shift amount
- `ex_rt_data`  in  32  operand B
- `ex_w_reg_addr`  in  5  GPR destination
- `ex_wd`  in  1  GPR write enable
- `ex_inst_in_delayslot`  in  1  current instruction is in a delay slot
- `ex_flush`  in  1  annul the current instruction and abort any divide
- `mem_wdata`  out  32  result to EX/MEM
- `mem_w_reg_addr`  out  5  pass-through of `ex_w_reg_addr`
- `mem_wd`  out  1  GPR write enable to EX/MEM
- `mem_inst_in_delayslot`  out  1  pass-through of `ex_inst_in_delayslot`
- `stall_req`  out  1  hold the IF, ID and ID/EX stages this cycle

## Operation
- ALU ops, all 32-bit and wrapping: ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
- Compare ops produce 0 or 1: SLT 0x2A (signed), SLTU 0x2B (unsigned).
- Shift ops shift `rt` by `rs[4:0]`: SLLV 0x04, SRLV 0x06, SRAV 0x07 (arithmetic).
- NOP 0x00, or any undefined code: `mem_wdata`=0 and `mem_wd`=0.
- HI/LO ops:
  - MFHI 0x10 / MFLO 0x12: result is the HI/LO register value.
  - MTHI 0x11 / MTLO 0x13: write `rs` into HI/LO at the clock edge.
- MULT 0x18 / MULTU 0x19: 64-bit product computed in a single cycle, signed or unsigned; HI gets `[63:32]`, LO gets `[31:0]` at the edge.
- DIV 0x1A / DIVU 0x1B: restoring radix-2 division in `div_unit`; LO gets the quotient, HI the remainder.
  - Signed divide works on magnitudes, then fixes signs: the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
  - Divide by zero: quotient 0xFFFF_FFFF, remainder = dividend, no trap.
- `mem_wd` = `ex_wd` and `!stall_req` and `!ex_flush`.
- `mem_w_reg_addr` and `mem_inst_in_delayslot` are passed through unchanged.
- Divider FSM:
  - IDLE: on DIV/DIVU with no flush, latch operands and go to RUN with count=0.
  - RUN: perform one iteration per cycle; move to DONE when count=`DIV_CYCLES`-1.
  - DONE: write HI/LO at the edge, then return to IDLE.
  - `ex_flush` in any state forces IDLE with no HI/LO write.
- Upstream must hold all `ex_*` inputs stable while `stall_req`=1.

## Timing
- Reset values: HI=0, LO=0, FSM=IDLE, count=0, `stall_req`=0, `mem_wd`=0, `mem_wdata`=0.
- Reset mid-divide returns the FSM to IDLE with no HI/LO write.
- Non-divide ops have zero-cycle combinational latency. HI/LO writes land at the end of the EX cycle, so an MFHI issued in the very next cycle sees the new value.
- `stall_req` is a combinational output. It is 1 while a DIV/DIVU is presented and the FSM is IDLE or RUN, and 0 in DONE.
- A divide presented in cycle 0 stalls cycles 0..`DIV_CYCLES` (33 cycles by default). DONE is cycle 33, and HI/LO are updated at the end of that cycle.
- `ex_flush` asserted together with a DIV start does not start the divider and drives `stall_req`=0.
- Back-to-back divides: the second one starts from IDLE in the cycle after DONE.

## Structure
- Package `cpu_defines` holds the aluop constants listed above and the divider state encodings IDLE/RUN/DONE.
- Sub-module `div_unit` contains the FSM, the count, the operand/remainder shift registers and the sign fix-up. Its interface is start, signed, op_a, op_b, flush, busy, done, quot, rem.
- The top level holds the ALU mux, the multiplier, the HI/LO registers and the stall logic.

## Test plan
- ADDU 0x7FFF_FFFF+1 -> 0x8000_0000 with `mem_wd`=1; SLT 0xFFFF_FFFF vs 1 -> 1; SLTU of the same operands -> 0; SRAV 0x8000_0000 by 4 -> 0xF800_0000.
- MULT 0xFFFF_FFFE × 3 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; the following MFLO -> 0xFFFF_FFFA.
- DIV −7 / 2 -> `stall_req` high for exactly 33 cycles, then LO=0xFFFF_FFFD and HI=0xFFFF_FFFF; DIVU 100/7 -> LO=14, HI=2.
- DIVU 5 / 0 -> LO=0xFFFF_FFFF, HI=5.
- `ex_flush` pulsed in RUN cycle 10 -> `stall_req` falls in that cycle and HI/LO keep their previous values; `rst` asserted mid-divide -> HI=LO=0 and FSM=IDLE immediately.
- MTHI 0x1234 followed by MFHI in the next cycle -> `mem_wdata`=0x1234; NOP -> `mem_wd`=0.
